// File: rtl/pmu_frame_serializer.sv
// Serializes a header word plus N data words into the PMU bit stream on tck_i.
// Each word goes out LSB-first and is optionally followed by its CRC-8, MSB-first.
module pmu_frame_serializer #(
  parameter int               WORD_W   = 64,
  parameter int               CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = 8'h07,
  parameter int               LEN_W    = 16,
  parameter int               GAP_CYC  = 2
) (
  input  logic              tck_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              checksum_en_i,
  input  logic [LEN_W-1:0]  word_count_i,
  input  logic [WORD_W-1:0] header_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              data_o,
  output logic              en_o,
  output logic              checksum_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              underrun_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CRC   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int CNT_W = $clog2((WORD_W > CRC_W) ? WORD_W : CRC_W);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(CRC_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              ck_q, ck_d;
  logic              data_q, data_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              underrun_q, underrun_d;

  logic              load_en;
  logic              slot_end;
  logic [WORD_W-1:0] load_word;

  // One step of the bit-serial CRC, fed with the bit currently on the wire.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic             b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  // shift_q holds the bits not yet sent; crc_q already covers the bit on data_q.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    remain_d   = remain_q;
    ck_d       = ck_q;
    data_d     = data_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    load_en    = 1'b0;
    slot_end   = 1'b0;
    load_word  = word_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load_en    = 1'b1;
          load_word  = header_i;
          remain_d   = word_count_i;
          ck_d       = checksum_en_i;
          underrun_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (cnt_q != LAST_BIT) begin
          shift_d = {1'b0, shift_q[WORD_W-1:1]};
          data_d  = shift_q[0];
          crc_d   = crc_step(crc_q, shift_q[0]);
          cnt_d   = cnt_q + 1'b1;
        end else if (ck_q) begin
          state_d = S_CRC;
          cnt_d   = '0;
          data_d  = crc_q[CRC_W-1];
          crc_d   = {crc_q[CRC_W-2:0], 1'b0};
        end else begin
          slot_end = 1'b1;
        end
      end
      S_CRC: begin
        if (cnt_q != LAST_CRC) begin
          data_d = crc_q[CRC_W-1];
          crc_d  = {crc_q[CRC_W-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end else begin
          slot_end = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = S_IDLE;
          ck_d    = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A slot ending with ready high either chains the next word or underruns.
    if (slot_end) begin
      if (ready_q && word_valid_i) begin
        load_en  = 1'b1;
        remain_d = remain_q - LEN_W'(1);
      end else begin
        state_d    = S_GAP;
        gap_d      = '0;
        underrun_d = ready_q ? 1'b1 : underrun_q;
        done_d     = ~ready_q;
      end
    end

    if (load_en) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      shift_d = {1'b0, load_word[WORD_W-1:1]};
      data_d  = load_word[0];
      crc_d   = crc_step('0, load_word[0]);
    end

    en_d = (state_d == S_SHIFT) || (state_d == S_CRC);
    if (!en_d) begin
      data_d = 1'b0;
    end
    busy_d  = (state_d != S_IDLE);
    ready_d = (remain_d != '0) &&
              (((state_d == S_SHIFT) && !ck_d && (cnt_d == LAST_BIT)) ||
               ((state_d == S_CRC) && (cnt_d == LAST_CRC)));
  end

  always_ff @(posedge tck_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      crc_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      remain_q   <= '0;
      ck_q       <= 1'b0;
      data_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      remain_q   <= remain_d;
      ck_q       <= ck_d;
      data_q     <= data_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign word_ready_o  = ready_q;
  assign data_o        = data_q;
  assign en_o          = en_q;
  assign checksum_en_o = ck_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_pmu_frame_serializer.sv
// Directed bench for pmu_frame_serializer: frame timing, CRC, underrun, resets, ignored starts.
// Output vector order: {en, data, ready, done, busy, checksum_en, underrun}.
module tb_pmu_frame_serializer;

  logic        tck_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        checksum_en_i = 1'b0;
  logic [15:0] word_count_i = '0;
  logic [63:0] header_i = '0;
  logic [63:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o, data_o, en_o, checksum_en_o, busy_o, done_o, underrun_o;
  logic [6:0]  obs;

  int checks = 0;
  int passes = 0;

  localparam logic [63:0] PLAIN_WORD = 64'h10BC_3800_0380_2007;

  pmu_frame_serializer dut (
    .tck_i         (tck_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .checksum_en_i (checksum_en_i),
    .word_count_i  (word_count_i),
    .header_i      (header_i),
    .word_i        (word_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .data_o        (data_o),
    .en_o          (en_o),
    .checksum_en_o (checksum_en_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .underrun_o    (underrun_o)
  );

  always #5 tck_i = ~tck_i;

  assign obs = {en_o, data_o, word_ready_o, done_o, busy_o, checksum_en_o, underrun_o};

  // CRC-8 reference as polynomial long division; word bit 0 is the highest-order term.
  function automatic logic [7:0] crc_ref(input logic [63:0] w);
    logic [71:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) m[71-i] = w[i];
    for (int j = 71; j >= 8; j--) begin
      if (m[j]) m[j -: 9] = m[j -: 9] ^ 9'h107;
    end
    return m[7:0];
  endfunction

  // Expected outputs at frame cycle c of a frame that completes cleanly.
  function automatic logic [6:0] exp_vec(input logic [63:0] hdr, input logic [63:0] wd,
                                         input int n, input bit ck, input int c);
    int L, F, slot, pos;
    logic en, d, rdy, dn, bsy, cko;
    logic [63:0] w;
    logic [7:0] cr;
    L    = ck ? 72 : 64;
    F    = (n + 1) * L;
    en   = (c >= 1) && (c <= F);
    d    = 1'b0;
    if (en) begin
      slot = (c - 1) / L;
      pos  = (c - 1) % L;
      w    = (slot == 0) ? hdr : wd;
      cr   = crc_ref(w);
      d    = (pos < 64) ? w[pos] : cr[7-(pos-64)];
    end
    rdy = en && (c % L == 0) && (c / L <= n);
    dn  = (c == F + 1);
    bsy = (c >= 1) && (c <= F + 2);
    cko = ck && bsy;
    return {en, d, rdy, dn, bsy, cko, 1'b0};
  endfunction

  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask

  // Leaves the bench at the observation point of frame cycle 1.
  task automatic start_frame(input logic [63:0] hdr, input int n, input bit ck);
    tick();
    header_i      = hdr;
    word_count_i  = 16'(n);
    checksum_en_i = ck;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== 7'b0) $display("[TB] FAIL reset_hold got=%b exp=%b", obs, 7'b0);
    else passes++;
    rst_i = 1'b1;
    tick();
    checks++;
    if (obs !== 7'b0) $display("[TB] FAIL idle_after_reset got=%b exp=%b", obs, 7'b0);
    else passes++;
  endtask

  task automatic test_plain_frame(input string name);
    logic [6:0] exp;
    word_i       = PLAIN_WORD;
    word_valid_i = 1'b1;
    start_frame(64'h3, 3, 1'b0);
    for (int c = 1; c <= 262; c++) begin
      exp = exp_vec(64'h3, PLAIN_WORD, 3, 1'b0, c);
      checks++;
      if (obs !== exp) $display("[TB] FAIL %s c=%0d got=%b exp=%b", name, c, obs, exp);
      else passes++;
      tick();
    end
  endtask

  task automatic test_crc_frame();
    logic [6:0]  exp;
    logic [63:0] hdr;
    hdr          = 64'h4000_0000_0000_0006;
    word_i       = 64'h0;
    word_valid_i = 1'b1;
    start_frame(hdr, 3, 1'b1);
    for (int c = 1; c <= 294; c++) begin
      exp = exp_vec(hdr, 64'h0, 3, 1'b1, c);
      checks++;
      if (obs !== exp) $display("[TB] FAIL crc_frame c=%0d got=%b exp=%b", c, obs, exp);
      else passes++;
      tick();
    end
  endtask

  task automatic test_underrun();
    logic [6:0]  exp;
    logic [63:0] hdr, wd;
    hdr          = 64'hA5A5_0000_FFFF_1234;
    wd           = 64'h0123_4567_89AB_CDEF;
    word_i       = wd;
    word_valid_i = 1'b1;
    start_frame(hdr, 2, 1'b0);
    for (int c = 1; c <= 134; c++) begin
      if (c <= 128) exp = exp_vec(hdr, wd, 2, 1'b0, c);
      else          exp = {4'b0000, (c <= 130), 1'b0, 1'b1};
      checks++;
      if (obs !== exp) $display("[TB] FAIL underrun c=%0d got=%b exp=%b", c, obs, exp);
      else passes++;
      if (c == 128) word_valid_i = 1'b0;
      if (c == 129) word_valid_i = 1'b1;
      tick();
    end
    // A fresh N=0 frame must clear the sticky flag.
    start_frame(64'h8000_0000_0000_0001, 0, 1'b0);
    for (int c = 1; c <= 68; c++) begin
      exp = exp_vec(64'h8000_0000_0000_0001, wd, 0, 1'b0, c);
      checks++;
      if (obs !== exp) $display("[TB] FAIL underrun_clear_n0 c=%0d got=%b exp=%b", c, obs, exp);
      else passes++;
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [6:0]  exp;
    logic [63:0] hdr;
    hdr          = 64'hDEAD_BEEF_0000_0001;
    word_i       = PLAIN_WORD;
    word_valid_i = 1'b1;
    start_frame(hdr, 3, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      exp = exp_vec(hdr, PLAIN_WORD, 3, 1'b0, c);
      checks++;
      if (obs !== exp) $display("[TB] FAIL pre_reset c=%0d got=%b exp=%b", c, obs, exp);
      else passes++;
      if (c < 40) tick();
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0) $display("[TB] FAIL async_reset got=%b exp=%b", obs, 7'b0);
    else passes++;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    checks++;
    if (obs !== 7'b0) $display("[TB] FAIL post_reset_idle got=%b exp=%b", obs, 7'b0);
    else passes++;
    test_plain_frame("plain_after_reset");
  endtask

  task automatic test_n0_crc();
    logic [6:0]  exp;
    logic [63:0] hdr;
    hdr = 64'hFFFF_0000_1234_8001;
    start_frame(hdr, 0, 1'b1);
    for (int c = 1; c <= 76; c++) begin
      exp = exp_vec(hdr, word_i, 0, 1'b1, c);
      checks++;
      if (obs !== exp) $display("[TB] FAIL n0_crc c=%0d got=%b exp=%b", c, obs, exp);
      else passes++;
      tick();
    end
  endtask

  task automatic test_start_ignored();
    logic [6:0]  exp;
    logic [63:0] hdr;
    hdr          = 64'h0F0F_0F0F_F0F0_F0F0;
    word_i       = PLAIN_WORD;
    word_valid_i = 1'b1;
    start_frame(hdr, 1, 1'b0);
    for (int c = 1; c <= 136; c++) begin
      exp = exp_vec(hdr, PLAIN_WORD, 1, 1'b0, c);
      checks++;
      if (obs !== exp) $display("[TB] FAIL start_ignored c=%0d got=%b exp=%b", c, obs, exp);
      else passes++;
      if (c == 30 || c == 129) begin
        start_i       = 1'b1;
        word_count_i  = 16'd5;
        checksum_en_i = 1'b1;
        header_i      = ~hdr;
      end
      if (c == 31 || c == 131) begin
        start_i       = 1'b0;
        checksum_en_i = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_plain_frame("plain");
    test_crc_frame();
    test_underrun();
    test_reset_mid_frame();
    test_n0_crc();
    test_start_ignored();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pmu_frame_serializer.md
Name: pmu_frame_serializer

Overview:
- Upstream feeder for the PMU. Accepts parallel 64-bit configuration words and emits the PMU serial frame on `tck_i`, driving the PMU `data_i`, `en_i` and `checksum_en_i`.
- Frame layout: one header word, then N data words. Every word is sent LSB-first. When checksum is enabled, each word is followed by its CRC-8.

Parameters:
- WORD_W, 64, payload bits per word.
- CRC_W, 8, CRC bits appended per word when checksum is enabled.
- CRC_POLY, 8'h07, CRC-8 polynomial (implicit x^8).
- LEN_W, 16, width of the data-word count.
- GAP_CYC, 2, minimum idle cycles with `en_o` low after a frame.

Ports:
- tck_i  in  1  clock (JTAG TCK domain); all logic on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  frame request; sampled in IDLE only.
- checksum_en_i  in  1  CRC mode for the frame; captured with `start_i`.
- word_count_i  in  LEN_W  number of data words N; captured with `start_i`.
- header_i  in  WORD_W  header word; captured with `start_i`.
- word_i  in  WORD_W  data word.
- word_valid_i  in  1  `word_i` is valid.
- word_ready_o  out  1  serializer accepts `word_i` this cycle.
- data_o  out  1  serial bit to PMU `data_i`.
- en_o  out  1  to PMU `en_i`; high for exactly the frame bits.
- checksum_en_o  out  1  to PMU `checksum_en_i`; captured mode, held stable from start through GAP.
- busy_o  out  1  high in every state other than IDLE.
- done_o  out  1  one-cycle pulse on clean frame completion.
- underrun_o  out  1  sticky abort flag; cleared on next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, shift/CRC registers 0. Reset mid-frame aborts immediately with the same values; no done pulse.
- States: IDLE, SHIFT, CRC, GAP. All outputs are registered.
- IDLE, start_i=1:
  - capture header_i, word_count_i, checksum_en_i;
  - clear underrun_o;
  - go to SHIFT.
  - Next cycle: en_o=1, data_o=header[0]. Bit k of a word appears k+1 cycles after the word is loaded.
- SHIFT: one bit per cycle, LSB first, WORD_W cycles.
  - CRC register updates every bit: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - CRC register is reset to 0 at the start of every word.
- CRC (checksum mode only): CRC_W cycles, transmitting crc[7] first down to crc[0].
- Word boundary handshake:
  - word_ready_o=1 only in the last bit cycle of the current word slot (last payload bit if checksum off, last CRC bit if on), and only while data words remain.
  - A transfer occurs when word_valid_i && word_ready_o. The new word's bit 0 is driven the next cycle, so en_o stays high with no bubble.
  - Word slot length is WORD_W, or WORD_W+CRC_W with checksum on.
  - Frame length = (1+N) slots, contiguous.
- Underrun: word_ready_o=1 with word_valid_i=0.
  - Abort: next cycle en_o=0, data_o=0, underrun_o=1, go to GAP. No done pulse.
- Completion: after the last bit of the last slot, the next cycle has en_o=0, data_o=0 and done_o=1 for 1 cycle, and the state enters GAP.
- GAP: GAP_CYC cycles with en_o=0, then IDLE. checksum_en_o returns to 0 on entry to IDLE.
- N=0: header slot only, then done.
- N=2^LEN_W-1 is legal. The remaining-word counter decrements per accepted word and never wraps.
- start_i while busy_o=1 is ignored; nothing is latched.
- word_valid_i outside a ready cycle is ignored.

Test Plan:
- Plain frame: start with header=64'h3, N=3, checksum=0; supply words 64'h10BC3800038020 07 repeated.
  - en_o high for exactly 256 consecutive cycles.
  - data_o equals header LSB-first, then each word LSB-first.
  - word_ready_o pulses at frame cycles 64, 128, 192.
  - done_o pulses once at cycle 257.
  - en_o low for 2 cycles, then busy_o=0.
- CRC frame: header=64'h0000_0000_0000_0006 with bit 62 set, N=3 zero words, checksum=1.
  - en_o high for 288 cycles; checksum_en_o=1 throughout.
  - Each zero word is followed by 8'h00.
  - Header CRC bits match a bit-serial reference model of poly 0x07, init 0.
- Underrun: N=2, withhold word_valid_i at the second ready cycle.
  - en_o falls the next cycle; underrun_o=1; no done_o pulse.
  - The next start clears underrun_o.
- Reset mid-frame: assert rst_i=0 asynchronously during frame cycle 40.
  - en_o, data_o and busy_o are 0 immediately, without waiting for a clock edge.
  - After release, a new frame runs correctly.
- Corner cases:
  - N=0 gives a 64-cycle frame (72 with CRC), followed by done_o.
  - start_i pulsed during SHIFT and GAP is ignored: frame length is unchanged and no second frame starts.
